// File: rtl/theia_host_loader.sv
// Host-side Wishbone initiator: streams a block of words into each core selected by a mask,
// then runs the host-data-available / latched / latched-ack handshake with the GPU.
module theia_host_loader #(
  parameter int WB_WIDTH    = 32,
  parameter int MAX_CORES   = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 iStart,
  input  logic [MAX_CORES-1:0] iCoreMask,
  input  logic [WB_WIDTH-1:0]  iBaseAdr,
  input  logic [15:0]          iWordCount,
  input  logic [1:0]           iTag,
  input  logic [WB_WIDTH-1:0]  iSrcData,
  input  logic                 iSrcValid,
  output logic                 oSrcReady,
  output logic                 MST_O,
  output logic [MAX_CORES-1:0] SEL_O,
  output logic                 CYC_O,
  output logic                 STB_O,
  output logic                 WE_O,
  output logic [1:0]           TGA_O,
  output logic [WB_WIDTH-1:0]  ADR_O,
  output logic [WB_WIDTH-1:0]  DAT_O,
  input  logic                 ACK_I,
  output logic                 HDA_O,
  input  logic                 HDL_I,
  output logic                 HDLACK_O,
  output logic                 oBusy,
  output logic                 oDone,
  output logic                 oError
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    NEXTCORE = 3'd1,
    WAITSRC  = 3'd2,
    STROBE   = 3'd3,
    HSHAKE   = 3'd4,
    HDLACK   = 3'd5,
    FINISH   = 3'd6
  } state_t;

  state_t               state_r;
  logic [MAX_CORES-1:0] rem_mask_r;
  logic [MAX_CORES-1:0] pick_s;
  logic [MAX_CORES-1:0] rem_after_pick_s;
  logic [WB_WIDTH-1:0]  base_r;
  logic [15:0]          count_r;
  logic [15:0]          idx_r;
  logic [15:0]          idx_next_s;
  logic [1:0]           tag_r;
  logic [TW-1:0]        tmo_r;

  // Lowest set bit of the cores still waiting to be loaded.
  assign pick_s           = rem_mask_r & (~rem_mask_r + {{(MAX_CORES-1){1'b0}}, 1'b1});
  assign rem_after_pick_s = rem_mask_r & ~pick_s;
  assign idx_next_s       = idx_r + 16'd1;

  // The pop coincides with the accepted ACK so the source can advance before the next WAITSRC.
  assign oSrcReady = (state_r == STROBE) && STB_O && ACK_I && !RST_I;

  // Loader state machine with registered bus and status outputs.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_r    <= IDLE;
      rem_mask_r <= {MAX_CORES{1'b0}};
      base_r     <= {WB_WIDTH{1'b0}};
      count_r    <= 16'd0;
      idx_r      <= 16'd0;
      tag_r      <= 2'd0;
      tmo_r      <= {TW{1'b0}};
      MST_O      <= 1'b0;
      SEL_O      <= {MAX_CORES{1'b0}};
      CYC_O      <= 1'b0;
      STB_O      <= 1'b0;
      WE_O       <= 1'b0;
      TGA_O      <= 2'd0;
      ADR_O      <= {WB_WIDTH{1'b0}};
      DAT_O      <= {WB_WIDTH{1'b0}};
      HDA_O      <= 1'b0;
      HDLACK_O   <= 1'b0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oError     <= 1'b0;
    end else begin
      oDone    <= 1'b0;
      HDLACK_O <= 1'b0;
      case (state_r)
        IDLE: begin
          if (iStart) begin
            rem_mask_r <= iCoreMask;
            base_r     <= iBaseAdr;
            count_r    <= iWordCount;
            tag_r      <= iTag;
            oError     <= 1'b0;
            oBusy      <= 1'b1;
            state_r    <= (iCoreMask == {MAX_CORES{1'b0}}) ? FINISH : NEXTCORE;
          end else begin
            state_r <= IDLE;
          end
        end
        NEXTCORE: begin
          rem_mask_r <= rem_after_pick_s;
          SEL_O      <= pick_s;
          MST_O      <= 1'b1;
          CYC_O      <= 1'b1;
          idx_r      <= 16'd0;
          if (count_r != 16'd0) begin
            state_r <= WAITSRC;
          end else if (rem_after_pick_s != {MAX_CORES{1'b0}}) begin
            state_r <= NEXTCORE;
          end else begin
            // Nothing to write anywhere: go straight to the handshake with the bus released.
            SEL_O   <= {MAX_CORES{1'b0}};
            MST_O   <= 1'b0;
            CYC_O   <= 1'b0;
            HDA_O   <= 1'b1;
            state_r <= HSHAKE;
          end
        end
        WAITSRC: begin
          if (iSrcValid) begin
            DAT_O   <= iSrcData;
            ADR_O   <= base_r + {{(WB_WIDTH-16){1'b0}}, idx_r};
            TGA_O   <= tag_r;
            STB_O   <= 1'b1;
            WE_O    <= 1'b1;
            tmo_r   <= {TW{1'b0}};
            state_r <= STROBE;
          end else begin
            state_r <= WAITSRC;
          end
        end
        STROBE: begin
          if (ACK_I) begin
            STB_O <= 1'b0;
            WE_O  <= 1'b0;
            idx_r <= idx_next_s;
            if (idx_next_s != count_r) begin
              state_r <= WAITSRC;
            end else if (rem_mask_r != {MAX_CORES{1'b0}}) begin
              state_r <= NEXTCORE;
            end else begin
              SEL_O   <= {MAX_CORES{1'b0}};
              MST_O   <= 1'b0;
              CYC_O   <= 1'b0;
              HDA_O   <= 1'b1;
              state_r <= HSHAKE;
            end
          end else if (tmo_r == TW'(ACK_TIMEOUT - 1)) begin
            STB_O   <= 1'b0;
            WE_O    <= 1'b0;
            CYC_O   <= 1'b0;
            MST_O   <= 1'b0;
            SEL_O   <= {MAX_CORES{1'b0}};
            oError  <= 1'b1;
            state_r <= FINISH;
          end else begin
            tmo_r <= tmo_r + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        HSHAKE: begin
          if (HDL_I) begin
            HDA_O    <= 1'b0;
            HDLACK_O <= 1'b1;
            state_r  <= HDLACK;
          end else begin
            state_r <= HSHAKE;
          end
        end
        HDLACK: begin
          state_r <= FINISH;
        end
        FINISH: begin
          oDone   <= 1'b1;
          oBusy   <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_theia_host_loader.sv
// Directed bench for theia_host_loader: Wishbone slave and GPU handshake responders,
// a counting source, and hand-computed expectations checked with immediate assertions.
module tb_theia_host_loader;

  logic        clk = 1'b0;
  logic        RST_I;
  logic        iStart;
  logic [3:0]  iCoreMask;
  logic [31:0] iBaseAdr;
  logic [15:0] iWordCount;
  logic [1:0]  iTag;
  logic [31:0] iSrcData;
  logic        iSrcValid;
  logic        oSrcReady;
  logic        MST_O;
  logic [3:0]  SEL_O;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic [1:0]  TGA_O;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic        ACK_I;
  logic        HDA_O;
  logic        HDL_I;
  logic        HDLACK_O;
  logic        oBusy;
  logic        oDone;
  logic        oError;

  int checks = 0;
  int errors = 0;

  // Monitor state
  int cyc_n = 0, pops = 0, beat_n = 0, stbr_n = 0, done_n = 0, hdlack_n = 0, hda_n = 0, act_n = 0;
  int stb_rise_cyc = 0, cyc_fall_cyc = 0, stb_in_gap = 0, gap_cnt = 0, gap_at = -1;
  logic prev_stb = 1'b0, prev_cyc = 1'b0, slave_prev = 1'b0;
  logic ack_en = 1'b1, src_en = 1'b1;
  logic [31:0] log_adr [0:63];
  logic [31:0] log_dat [0:63];
  logic [3:0]  log_sel [0:63];
  logic [1:0]  log_tga [0:63];
  int          log_cyc [0:63];

  theia_host_loader #(.WB_WIDTH(32), .MAX_CORES(4), .ACK_TIMEOUT(8)) dut (
    .CLK_I(clk), .RST_I(RST_I), .iStart(iStart), .iCoreMask(iCoreMask), .iBaseAdr(iBaseAdr),
    .iWordCount(iWordCount), .iTag(iTag), .iSrcData(iSrcData), .iSrcValid(iSrcValid),
    .oSrcReady(oSrcReady), .MST_O(MST_O), .SEL_O(SEL_O), .CYC_O(CYC_O), .STB_O(STB_O),
    .WE_O(WE_O), .TGA_O(TGA_O), .ADR_O(ADR_O), .DAT_O(DAT_O), .ACK_I(ACK_I), .HDA_O(HDA_O),
    .HDL_I(HDL_I), .HDLACK_O(HDLACK_O), .oBusy(oBusy), .oDone(oDone), .oError(oError)
  );

  always #5 clk = ~clk;

  assign iSrcData  = 32'hA000_0000 + 32'(pops);
  assign iSrcValid = src_en && (gap_cnt == 0);
  assign HDL_I     = HDA_O;

  // Wishbone slave: acknowledge in the cycle after STB_O is first seen.
  always @(posedge clk) begin
    #1;
    ACK_I      = ack_en && STB_O && slave_prev && !ACK_I;
    slave_prev = STB_O;
  end

  // Mid-cycle monitor: pops, accepted beats, edges and pulse counts.
  always @(negedge clk) begin
    cyc_n++;
    if (gap_cnt > 0) begin
      if (STB_O) stb_in_gap++;
      gap_cnt--;
    end
    if (oSrcReady) begin
      pops++;
      if (pops == gap_at) gap_cnt = 6;
    end
    if (STB_O && ACK_I) begin
      log_adr[beat_n % 64] = ADR_O;
      log_dat[beat_n % 64] = DAT_O;
      log_sel[beat_n % 64] = SEL_O;
      log_tga[beat_n % 64] = TGA_O;
      log_cyc[beat_n % 64] = cyc_n;
      beat_n++;
    end
    if (STB_O && !prev_stb) begin stbr_n++; stb_rise_cyc = cyc_n; end
    if (!CYC_O && prev_cyc) cyc_fall_cyc = cyc_n;
    if (oDone) done_n++;
    if (HDLACK_O) hdlack_n++;
    if (HDA_O) hda_n++;
    if (CYC_O || STB_O || MST_O || HDA_O || (SEL_O != 4'd0)) act_n++;
    prev_stb = STB_O;
    prev_cyc = CYC_O;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [3:0] m, input logic [31:0] b, input logic [15:0] c, input logic [1:0] t);
    @(posedge clk); #2;
    iCoreMask = m; iBaseAdr = b; iWordCount = c; iTag = t; iStart = 1'b1;
    @(posedge clk); #2;
    iStart = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (oDone) begin seen = 1'b1; break; end
      @(posedge clk); #2;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  function automatic logic [31:0] outs_vec();
    return 32'({MST_O, SEL_O, CYC_O, STB_O, WE_O, TGA_O, HDA_O, HDLACK_O, oBusy, oDone, oError, oSrcReady});
  endfunction

  initial begin
    int p0, b0, s0, d0, h0, a0, hk0;
    RST_I = 1'b1; iStart = 1'b0; iCoreMask = 4'd0; iBaseAdr = 32'd0; iWordCount = 16'd0; iTag = 2'd0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_outs", outs_vec(), 32'd0);
    chk("rst_adr", ADR_O, 32'd0);
    chk("rst_dat", DAT_O, 32'd0);
    RST_I = 1'b0;

    // Two cores, three words each
    p0 = pops; b0 = beat_n; d0 = done_n; hk0 = hdlack_n; h0 = hda_n;
    start(4'b0101, 32'h100, 16'd3, 2'd2);
    chk("c1_busy", 32'(oBusy), 32'd1);
    chk("c1_sel", 32'(SEL_O), 32'd0);
    @(posedge clk); #2;
    chk("c2_sel_mst", 32'({SEL_O, MST_O, CYC_O, STB_O}), 32'b0001_1_1_0);
    @(posedge clk); #2;
    chk("c3_stb", 32'({STB_O, WE_O, TGA_O}), 32'b1_1_10);
    chk("c3_adr", ADR_O, 32'h100);
    @(posedge clk); #2;
    chk("c4_pop", 32'(oSrcReady), 32'd1);
    wait_done("t1_done");
    chk("t1_err", 32'(oError), 32'd0);
    chk("t1_busy", 32'(oBusy), 32'd0);
    chk("t1_pops", 32'(pops - p0), 32'd6);
    chk("t1_beats", 32'(beat_n - b0), 32'd6);
    for (int k = 0; k < 6; k++) begin
      chk("t1_sel", 32'(log_sel[(b0 + k) % 64]), (k < 3) ? 32'd1 : 32'd4);
      chk("t1_adr", log_adr[(b0 + k) % 64], 32'h100 + 32'(k % 3));
      chk("t1_dat", log_dat[(b0 + k) % 64], 32'hA000_0000 + 32'(p0 + k));
      chk("t1_tga", 32'(log_tga[(b0 + k) % 64]), 32'd2);
    end
    chk("t1_hda_seen", 32'(hda_n != h0), 32'd1);
    chk("t1_hdlack", 32'(hdlack_n - hk0), 32'd1);
    @(posedge clk); #2;
    chk("t1_done_once", 32'(done_n - d0), 32'd1);

    // Source stalls before the second word
    p0 = pops; b0 = beat_n; s0 = stb_in_gap;
    gap_at = pops + 1;
    start(4'b0001, 32'h200, 16'd3, 2'd1);
    wait_done("t2_done");
    chk("t2_stb_in_gap", 32'(stb_in_gap - s0), 32'd0);
    chk("t2_beats", 32'(beat_n - b0), 32'd3);
    chk("t2_pops", 32'(pops - p0), 32'd3);
    chk("t2_adr1", log_adr[(b0 + 1) % 64], 32'h201);
    chk("t2_dat1", log_dat[(b0 + 1) % 64], 32'hA000_0000 + 32'(p0 + 1));
    chk("t2_gap_len", 32'(log_cyc[(b0 + 1) % 64] - log_cyc[b0 % 64]), 32'd8);

    // ACK timeout
    ack_en = 1'b0;
    p0 = pops; h0 = hda_n;
    start(4'b0001, 32'h300, 16'd2, 2'd0);
    wait_done("t3_done");
    chk("t3_err", 32'(oError), 32'd1);
    chk("t3_pops", 32'(pops - p0), 32'd0);
    chk("t3_drop_delay", 32'(cyc_fall_cyc - stb_rise_cyc), 32'd8);
    chk("t3_no_hda", 32'(hda_n - h0), 32'd0);
    chk("t3_bus_idle", outs_vec() & 32'hFF80, 32'd0);
    ack_en = 1'b1;

    // Mask 0: clears error, no activity, done two cycles after start
    a0 = act_n;
    start(4'b0000, 32'h0, 16'd5, 2'd0);
    chk("t4_err_clr", 32'(oError), 32'd0);
    chk("t4_c1", 32'({oBusy, oDone}), 32'b10);
    @(posedge clk); #2;
    chk("t4_c2", 32'({oBusy, oDone}), 32'b01);
    @(posedge clk); #2;
    chk("t4_no_act", 32'(act_n - a0), 32'd0);

    // Count 0: no strobes but full handshake
    s0 = stbr_n; hk0 = hdlack_n; h0 = hda_n;
    start(4'b0001, 32'h500, 16'd0, 2'd0);
    wait_done("t5_done");
    chk("t5_no_stb", 32'(stbr_n - s0), 32'd0);
    chk("t5_hdlack", 32'(hdlack_n - hk0), 32'd1);
    chk("t5_hda_seen", 32'(hda_n != h0), 32'd1);

    // Address wrap
    b0 = beat_n;
    start(4'b0001, 32'hFFFF_FFFF, 16'd2, 2'd3);
    wait_done("t6_done");
    chk("t6_beats", 32'(beat_n - b0), 32'd2);
    chk("t6_adr0", log_adr[b0 % 64], 32'hFFFF_FFFF);
    chk("t6_adr1", log_adr[(b0 + 1) % 64], 32'h0000_0000);

    // Reset during the second strobe, then a clean rerun
    b0 = beat_n;
    start(4'b0001, 32'h400, 16'd3, 2'd0);
    begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if ((beat_n - b0 == 1) && STB_O) begin hit = 1'b1; break; end
        @(posedge clk); #2;
      end
      chk("t7_reach_beat2", 32'(hit), 32'd1);
    end
    p0 = pops;
    RST_I = 1'b1;
    @(posedge clk); #2;
    chk("t7_rst_outs", outs_vec(), 32'd0);
    RST_I = 1'b0;
    @(negedge clk); #1;
    chk("t7_no_pop", 32'(pops - p0), 32'd0);
    b0 = beat_n; p0 = pops;
    start(4'b0001, 32'h400, 16'd3, 2'd0);
    wait_done("t7_done");
    chk("t7_beats", 32'(beat_n - b0), 32'd3);
    chk("t7_adr0", log_adr[b0 % 64], 32'h400);
    chk("t7_adr2", log_adr[(b0 + 2) % 64], 32'h402);
    chk("t7_pops", 32'(pops - p0), 32'd3);
    chk("t7_err", 32'(oError), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
